addertree_final_accum: RTL and testbench

Pipelined consumer of the two-row (sum/carry) output of the multiplier compression tree. Each cycle it resolves one sum/carry pair into a signed product with a carry-propagate adder, accumulates products over a group delimited by `in_last`, and emits the saturated group total over a valid/ready handshake. It sits between the final adder-tree stage and the NPU output/activation path.

---
 rtl/npu_mac_pkg.sv | 10 +
 rtl/addertree_cpa.sv | 14 +
 rtl/addertree_final_accum.sv | 106 ++++++++++
 tb/tb_addertree_final_accum.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_mac_pkg.sv
// Shared widths and saturation limits for the NPU MAC datapath.
package npu_mac_pkg;

  localparam int unsigned PW_DEFAULT    = 20;
  localparam int unsigned ACC_W_DEFAULT = 32;

  localparam logic signed [ACC_W_DEFAULT-1:0] ACC_MAX = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
  localparam logic signed [ACC_W_DEFAULT-1:0] ACC_MIN = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/addertree_cpa.sv
// Carry-propagate adder resolving the compression tree's sum/carry rows, modulo 2^PW.
module addertree_cpa #(
  parameter int unsigned PW = 20
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] sum
);

  always_comb begin
    sum = a + b;
  end

endmodule

// File: rtl/addertree_final_accum.sv
// Resolves sum/carry pairs into signed products, accumulates them per group with
// saturation, and hands the group total downstream over valid/ready.
module addertree_final_accum
  import npu_mac_pkg::*;
#(
  parameter int unsigned PW    = PW_DEFAULT,
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_sum,
  input  logic [PW-1:0]    in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam logic [ACC_W-1:0] ACC_HI = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_LO = {1'b1, {(ACC_W-1){1'b0}}};

  logic             s1_valid;
  logic             s1_last;
  logic [PW-1:0]    s1_sum;
  logic [PW-1:0]    s1_carry;
  logic [PW-1:0]    p;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   t;
  logic             sat;
  logic             clamp_now;
  logic             advance;

  addertree_cpa #(.PW(PW)) u_cpa (
    .a   (s1_sum),
    .b   (s1_carry),
    .sum (p)
  );

  // Overflow of the ACC_W+1 sum shows as disagreement between its top two bits.
  always_comb begin
    p_ext     = {{(ACC_W-PW){p[PW-1]}}, p};
    t         = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};
    clamp_now = t[ACC_W] ^ t[ACC_W-1];
    if (!clamp_now) begin
      acc_next = t[ACC_W-1:0];
    end else if (t[ACC_W]) begin
      acc_next = ACC_LO;
    end else begin
      acc_next = ACC_HI;
    end
  end

  // Only a last element can be blocked, and only by a result still waiting downstream.
  always_comb begin
    advance  = s1_valid & ~(s1_last & out_valid & ~out_ready);
    in_ready = ~s1_valid | advance;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      s1_sum   <= in_sum;
      s1_carry <= in_carry;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (advance && s1_last) begin
        out_data  <= acc_next;
        out_sat   <= sat | clamp_now;
        out_valid <= 1'b1;
        acc       <= '0;
        sat       <= 1'b0;
      end else begin
        if (advance) begin
          acc <= acc_next;
          sat <= sat | clamp_now;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_addertree_final_accum.sv
// Randomized and directed checks of addertree_final_accum against an arithmetic group-sum model.
module tb_addertree_final_accum;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_sum = '0;
  logic [19:0] in_carry = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sat;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  bit          rdy_mode = 1'b0;
  bit          rdy_val = 1'b0;

  longint      m_acc = 0;
  bit          m_sat = 1'b0;
  logic [32:0] exp_q[$];

  addertree_final_accum #(.PW(20), .ACC_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Reference model: signed product from plain modular arithmetic, clamped running sum.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc = 0;
      m_sat = 1'b0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      longint p;
      p = (longint'(in_sum) + longint'(in_carry)) % (longint'(1) << 20);
      if (p >= (longint'(1) << 19)) p = p - (longint'(1) << 20);
      m_acc = m_acc + p;
      if (m_acc > MAXV) begin
        m_acc = MAXV;
        m_sat = 1'b1;
      end else if (m_acc < MINV) begin
        m_acc = MINV;
        m_sat = 1'b1;
      end
      if (in_last) begin
        exp_q.push_back({m_sat, m_acc[31:0]});
        m_acc = 0;
        m_sat = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e[31:0]));
        check("out_sat", 64'(out_sat), 64'(e[32]));
      end
    end
  end

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [19:0] s, input logic [19:0] c, input logic l);
    int unsigned n;
    n = 0;
    in_sum   = s;
    in_carry = c;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      n++;
      cycles(1);
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] held;

    // reset values
    cycles(3);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    rst_n = 1'b1;
    rdy_val = 1'b1;
    cycles(2);

    // group 5, -2, 7 and its output timing
    send(20'd3, 20'd2, 1'b0);
    send(20'hFFFFC, 20'd2, 1'b0);
    send(20'd4, 20'd3, 1'b1);
    check("lat_before", 64'(out_valid), 64'd0);
    cycles(1);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_data), 64'd10);
    cycles(1);
    check("lat_one_cycle", 64'(out_valid), 64'd0);

    // single-element group of -1, then a group starting from zero
    send(20'hFFFFF, 20'd0, 1'b1);
    send(20'd1, 20'd0, 1'b0);
    send(20'd2, 20'd0, 1'b1);
    drain();

    // stalled output with a second group queued behind it
    rdy_val = 1'b0;
    cycles(1);
    send(20'd100, 20'd0, 1'b0);
    send(20'd20, 20'd3, 1'b1);
    send(20'd7, 20'd0, 1'b0);
    send(20'd9, 20'd1, 1'b1);
    cycles(1);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_valid", 64'(out_valid), 64'd1);
    held = exp_q[0][31:0];
    for (int unsigned i = 0; i < 5; i++) begin
      cycles(1);
      check("stall_hold", 64'(out_data), 64'(held));
    end
    rdy_val = 1'b1;
    drain();

    // positive overflow, then a small group with a clean sat flag
    for (int unsigned i = 0; i < 4200; i++) send(20'h7FFFF, 20'd0, 1'(i == 4199));
    send(20'd1, 20'd1, 1'b1);
    drain();

    // CPA carry wrap contributes zero
    send(20'd5, 20'd0, 1'b0);
    send(20'hFFFFF, 20'd1, 1'b0);
    send(20'd2, 20'd0, 1'b1);
    drain();

    // reset with a held result and a partial group
    rdy_val = 1'b0;
    cycles(1);
    send(20'd11, 20'd0, 1'b1);
    send(20'd2, 20'd0, 1'b0);
    cycles(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_sat", 64'(out_sat), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    cycles(2);
    rst_n = 1'b1;
    rdy_val = 1'b1;
    cycles(1);
    send(20'd1, 20'd0, 1'b0);
    send(20'd2, 20'd0, 1'b0);
    send(20'd3, 20'd0, 1'b1);
    cycles(1);
    check("post_rst_sum", 64'(out_data), 64'd6);
    drain();

    // randomized groups with random backpressure and input bubbles
    rdy_mode = 1'b1;
    for (int unsigned g = 0; g < 40; g++) begin
      int unsigned len;
      bit big;
      len = $urandom_range(1, 5);
      big = 1'($urandom_range(0, 1));
      for (int unsigned k = 0; k < len; k++) begin
        logic [19:0] s, c;
        if ($urandom_range(0, 3) == 0) cycles(1);
        s = big ? 20'($urandom) : 20'($urandom_range(0, 255));
        c = big ? 20'($urandom) : 20'($urandom_range(0, 255));
        send(s, c, 1'(k == len - 1));
      end
    end
    rdy_mode = 1'b0;
    rdy_val = 1'b1;
    cycles(1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
